// File: rtl/add_sub_4bit_checker.sv
// Golden-model response monitor for the 4-bit add/sub datapath: saturating pass/fail counts, sticky first-error mask, optional HALT.
// Define ADD_SUB_CHK_CAPTURE_EN to add cap_* ports that latch the first failing vector.
module add_sub_4bit_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             add_sub_i,
  input  logic [WIDTH-1:0] S_i,
  input  logic             C_i,
  input  logic             N_i,
  input  logic             Z_i,
  input  logic             V_i,
  input  logic             halt_on_err_i,
  input  logic             clear_i,
  output logic             pass_o,
  output logic             fail_o,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic             err_o,
  output logic [4:0]       err_mask_o,
`ifdef ADD_SUB_CHK_CAPTURE_EN
  output logic [WIDTH-1:0] cap_A_o,
  output logic [WIDTH-1:0] cap_B_o,
  output logic             cap_op_o,
  output logic [WIDTH-1:0] cap_S_o,
`endif
  output logic             halted_o
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [0:0]       state_q, state_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             err_q, err_d;
  logic [4:0]       err_mask_q, err_mask_d;
`ifdef ADD_SUB_CHK_CAPTURE_EN
  logic [WIDTH-1:0] cap_a_q, cap_a_d;
  logic [WIDTH-1:0] cap_b_q, cap_b_d;
  logic             cap_op_q, cap_op_d;
  logic [WIDTH-1:0] cap_s_q, cap_s_d;
`endif

  // Golden result: subtract is A + ~B + 1, so carry means no-borrow.
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   gold_sum;
  logic             gold_n, gold_z, gold_v;
  logic [4:0]       mismatch;
  logic             do_check;

  assign bx       = add_sub_i ? ~B_i : B_i;
  assign gold_sum = {1'b0, A_i} + {1'b0, bx} + (WIDTH+1)'(add_sub_i);
  assign gold_n   = gold_sum[WIDTH-1];
  assign gold_z   = (gold_sum[WIDTH-1:0] == '0);
  assign gold_v   = (A_i[WIDTH-1] == bx[WIDTH-1]) && (gold_sum[WIDTH-1] != A_i[WIDTH-1]);

  assign mismatch = {(S_i != gold_sum[WIDTH-1:0]), (C_i != gold_sum[WIDTH]),
                     (N_i != gold_n), (Z_i != gold_z), (V_i != gold_v)};

  assign do_check = valid_i && (state_q == ST_RUN) && !clear_i;

  always_comb begin
    state_d    = state_q;
    pass_d     = 1'b0;
    fail_d     = 1'b0;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    err_d      = err_q;
    err_mask_d = err_mask_q;
`ifdef ADD_SUB_CHK_CAPTURE_EN
    cap_a_d    = cap_a_q;
    cap_b_d    = cap_b_q;
    cap_op_d   = cap_op_q;
    cap_s_d    = cap_s_q;
`endif
    if (clear_i) begin
      state_d    = ST_RUN;
      pass_cnt_d = '0;
      fail_cnt_d = '0;
      err_d      = 1'b0;
      err_mask_d = '0;
`ifdef ADD_SUB_CHK_CAPTURE_EN
      cap_a_d    = '0;
      cap_b_d    = '0;
      cap_op_d   = 1'b0;
      cap_s_d    = '0;
`endif
    end else if (do_check) begin
      if (mismatch == '0) begin
        pass_d = 1'b1;
        if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + CNT_W'(1);
      end else begin
        fail_d = 1'b1;
        if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + CNT_W'(1);
        // Only the first failure is recorded; later ones leave mask/capture alone.
        if (!err_q) begin
          err_mask_d = mismatch;
`ifdef ADD_SUB_CHK_CAPTURE_EN
          cap_a_d    = A_i;
          cap_b_d    = B_i;
          cap_op_d   = add_sub_i;
          cap_s_d    = S_i;
`endif
        end
        err_d = 1'b1;
        if (halt_on_err_i) state_d = ST_HALT;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_RUN;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      err_q      <= 1'b0;
      err_mask_q <= '0;
`ifdef ADD_SUB_CHK_CAPTURE_EN
      cap_a_q    <= '0;
      cap_b_q    <= '0;
      cap_op_q   <= 1'b0;
      cap_s_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      err_q      <= err_d;
      err_mask_q <= err_mask_d;
`ifdef ADD_SUB_CHK_CAPTURE_EN
      cap_a_q    <= cap_a_d;
      cap_b_q    <= cap_b_d;
      cap_op_q   <= cap_op_d;
      cap_s_q    <= cap_s_d;
`endif
    end
  end

  assign pass_o     = pass_q;
  assign fail_o     = fail_q;
  assign pass_cnt_o = pass_cnt_q;
  assign fail_cnt_o = fail_cnt_q;
  assign err_o      = err_q;
  assign err_mask_o = err_mask_q;
  assign halted_o   = (state_q == ST_HALT);
`ifdef ADD_SUB_CHK_CAPTURE_EN
  assign cap_A_o    = cap_a_q;
  assign cap_B_o    = cap_b_q;
  assign cap_op_o   = cap_op_q;
  assign cap_S_o    = cap_s_q;
`endif

endmodule

// File: tb/tb_add_sub_4bit_checker.sv
// Directed bench for add_sub_4bit_checker: scoreboard of expected output snapshots, one popped per clock.
module tb_add_sub_4bit_checker;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic             pass;
    logic             fail;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] fcnt;
    logic             err;
    logic [4:0]       mask;
    logic             halted;
`ifdef ADD_SUB_CHK_CAPTURE_EN
    logic [3:0]       cap_a;
    logic [3:0]       cap_b;
    logic             cap_op;
    logic [3:0]       cap_s;
`endif
  } obs_t;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic valid_i, add_sub_i, C_i, N_i, Z_i, V_i, halt_on_err_i, clear_i;
  logic [WIDTH-1:0] A_i, B_i, S_i;
  logic pass_o, fail_o, err_o, halted_o;
  logic [CNT_W-1:0] pass_cnt_o, fail_cnt_o;
  logic [4:0] err_mask_o;
`ifdef ADD_SUB_CHK_CAPTURE_EN
  logic [WIDTH-1:0] cap_A_o, cap_B_o, cap_S_o;
  logic cap_op_o;
`endif

  obs_t obs;
  obs_t m;
  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk_i = ~clk_i;

  add_sub_4bit_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .A_i(A_i), .B_i(B_i),
    .add_sub_i(add_sub_i), .S_i(S_i), .C_i(C_i), .N_i(N_i), .Z_i(Z_i), .V_i(V_i),
    .halt_on_err_i(halt_on_err_i), .clear_i(clear_i),
    .pass_o(pass_o), .fail_o(fail_o), .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o),
    .err_o(err_o), .err_mask_o(err_mask_o),
`ifdef ADD_SUB_CHK_CAPTURE_EN
    .cap_A_o(cap_A_o), .cap_B_o(cap_B_o), .cap_op_o(cap_op_o), .cap_S_o(cap_S_o),
`endif
    .halted_o(halted_o)
  );

`ifdef ADD_SUB_CHK_CAPTURE_EN
  assign obs = {pass_o, fail_o, pass_cnt_o, fail_cnt_o, err_o, err_mask_o, halted_o,
                cap_A_o, cap_B_o, cap_op_o, cap_S_o};
`else
  assign obs = {pass_o, fail_o, pass_cnt_o, fail_cnt_o, err_o, err_mask_o, halted_o};
`endif

  // Reference {S,C,N,Z,V} from plain integer arithmetic, signed range test for V.
  function automatic logic [7:0] golden(input logic [3:0] a, input logic [3:0] b, input logic op);
    int ua, ub, sa, sb, r;
    logic [3:0] s;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = a[3] ? ua - 16 : ua;
    sb = b[3] ? ub - 16 : ub;
    if (op) begin
      c = (ua >= ub);
      s = 4'((ua - ub + 16) % 16);
      r = sa - sb;
    end else begin
      c = ((ua + ub) > 15);
      s = 4'((ua + ub) % 16);
      r = sa + sb;
    end
    v = (r > 7) || (r < -8);
    return {s, c, s[3], (s == 4'd0), v};
  endfunction

  task automatic check(input string tag, input obs_t o, input obs_t e);
    n_checks++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, o, e);
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input logic vld, input logic [3:0] a, input logic [3:0] b, input logic op,
                      input logic [7:0] res, input logic hoe, input logic clr, input string tag);
    obs_t e;
    logic [7:0] g;
    logic [4:0] mm;
    valid_i = vld; A_i = a; B_i = b; add_sub_i = op;
    {S_i, C_i, N_i, Z_i, V_i} = res;
    halt_on_err_i = hoe; clear_i = clr;
    m.pass = 1'b0;
    m.fail = 1'b0;
    if (clr) begin
      m = '0;
    end else if (vld && !m.halted) begin
      g  = golden(a, b, op);
      mm = {(g[7:4] != res[7:4]), (g[3] != res[3]), (g[2] != res[2]), (g[1] != res[1]), (g[0] != res[0])};
      if (mm == 5'd0) begin
        m.pass = 1'b1;
        if (m.pcnt != '1) m.pcnt = m.pcnt + 1'b1;
      end else begin
        m.fail = 1'b1;
        if (m.fcnt != '1) m.fcnt = m.fcnt + 1'b1;
        if (!m.err) begin
          m.mask = mm;
`ifdef ADD_SUB_CHK_CAPTURE_EN
          m.cap_a = a; m.cap_b = b; m.cap_op = op; m.cap_s = res[7:4];
`endif
        end
        m.err = 1'b1;
        if (hoe) m.halted = 1'b1;
      end
    end
    exp_q.push_back(m);
    @(posedge clk_i);
    #1;
    e = exp_q.pop_front();
    check(tag, obs, e);
  endtask

  initial begin
    logic [3:0] ra, rb;
    logic       rop;
    rst_ni = 1'b0;
    valid_i = 0; A_i = 0; B_i = 0; add_sub_i = 0; S_i = 0;
    C_i = 0; N_i = 0; Z_i = 0; V_i = 0; halt_on_err_i = 0; clear_i = 0;
    m = '0;
    #12;
    check("reset", obs, obs_t'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Basic add pass, then idle returns the pulse to 0
    step(1, 4'b0001, 4'b0010, 0, {4'b0011, 4'b0000}, 0, 0, "add_pass");
    step(0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, "idle1");

    // Subtract pass, then same vector with V wrong
    step(1, 4'b1001, 4'b0010, 1, {4'b0111, 4'b1001}, 0, 0, "sub_pass");
    step(1, 4'b1001, 4'b0010, 1, {4'b0111, 4'b1000}, 0, 0, "sub_fail_v");
    step(1, 4'b0000, 4'b0000, 1, golden(4'b0000, 4'b0000, 1), 0, 0, "sub_zero");
    step(1, 4'b0011, 4'b0101, 0, {4'b1000, 4'b0011}, 0, 0, "second_fail");

    // Halt on error: N wrong, then valid vectors are ignored
    step(1, 4'b0101, 4'b0101, 0, {4'b1010, 4'b0001}, 1, 0, "halt_fail");
    step(1, 4'b0001, 4'b0001, 0, golden(4'b0001, 4'b0001, 0), 0, 0, "halted1");
    step(1, 4'b0111, 4'b0001, 0, 8'hFF, 1, 0, "halted2");
    step(1, 4'b1000, 4'b0001, 1, golden(4'b1000, 4'b0001, 1), 0, 0, "halted3");
    step(0, 4'b0000, 4'b0000, 0, 8'h00, 0, 1, "clear_halt");
    step(1, 4'b1111, 4'b0001, 0, golden(4'b1111, 4'b0001, 0), 0, 0, "run_after_clear");

    // Back-to-back random passes to saturate the pass counter
    for (int i = 0; i < 260; i++) begin
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      rop = 1'($urandom_range(0, 1));
      step(1, ra, rb, rop, golden(ra, rb, rop), 0, 0, "sat_pass");
    end

    // Clear wins over a failing vector in the same cycle
    step(1, 4'b0100, 4'b0100, 0, 8'h00, 1, 1, "clear_vs_valid");
    step(0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, "after_clear");
    step(1, 4'b0110, 4'b0011, 1, golden(4'b0110, 4'b0011, 1), 0, 0, "pre_rst_pass");
    step(1, 4'b0110, 4'b0011, 1, 8'h00, 0, 0, "pre_rst_fail");

    // Asynchronous reset away from the clock edge
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_reset", obs, obs_t'(0));
    m = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Two different failures: only the first is captured
    step(1, 4'b0011, 4'b0100, 0, {4'b0000, 4'b0000}, 0, 0, "cap_first");
    step(1, 4'b1001, 4'b0001, 1, {4'b1111, 4'b1111}, 0, 0, "cap_second");
    step(0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, "cap_hold");
    step(1, 4'b1110, 4'b0010, 0, golden(4'b1110, 4'b0010, 0), 0, 0, "carry_pass");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
